// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - request and serial-output bundle for seq_pattern_tx
interface seq_pattern_tx_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1,
  parameter int REP_W = 4
) ();
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic [REP_W-1:0] rep;
  logic             D_out;
  logic             D_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, pat_len, rep,
    input  D_out, D_valid, busy, done
  );

  modport slave (
    input  start, abort, pattern, pat_len, rep,
    output D_out, D_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - MSB-first serial pattern transmitter with frame repeat
// Defining SEQ_TX_PARITY_EN appends an even-parity bit after every frame.
module seq_pattern_tx #(
  parameter int   PAT_W    = 8,
  parameter int   LEN_W    = $clog2(PAT_W) + 1,
  parameter int   REP_W    = 4,
  parameter logic IDLE_LVL = 1'b0
) (
  input logic             clk,
  input logic             rst,
  seq_pattern_tx_if.slave bus
);

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
`endif

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [PAT_W-1:0] PAT_ONE = PAT_W'(1);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_m1;
  logic [LEN_W-1:0] idx;
  logic [REP_W-1:0] frame_cnt;
  logic             d_out_q;
  logic             d_valid_q;
  logic             busy_q;
  logic             done_q;
`ifdef SEQ_TX_PARITY_EN
  logic             par_q;
`endif

  logic [LEN_W-1:0] eff_len_m1;
  logic             start_bit;
  logic             next_bit;
  logic             first_bit;
  logic             frame_end;

  // Out-of-range lengths (0 or above PAT_W) fall back to the full pattern width.
  always_comb begin
    eff_len_m1 = bus.pat_len - LEN_ONE;
    if (bus.pat_len == '0 || bus.pat_len > LEN_MAX) begin
      eff_len_m1 = LEN_MAX - LEN_ONE;
    end
    start_bit = |(bus.pattern & (PAT_ONE << eff_len_m1));
    next_bit  = |(pat_q & (PAT_ONE << (idx - LEN_ONE)));
    first_bit = |(pat_q & (PAT_ONE << len_m1));
`ifdef SEQ_TX_PARITY_EN
    frame_end = (state == S_PAR);
`else
    frame_end = (state == S_SHIFT) && (idx == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pat_q     <= '0;
      len_m1    <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      d_out_q   <= IDLE_LVL;
      d_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state != S_IDLE && bus.abort) begin
        state     <= S_IDLE;
        d_out_q   <= IDLE_LVL;
        d_valid_q <= 1'b0;
        busy_q    <= 1'b0;
      end else if (state == S_IDLE) begin
        // The first bit is registered on the accepting edge so it appears one cycle later.
        if (bus.start && !bus.abort) begin
          state     <= S_SHIFT;
          pat_q     <= bus.pattern;
          len_m1    <= eff_len_m1;
          idx       <= eff_len_m1;
          frame_cnt <= bus.rep;
          d_out_q   <= start_bit;
          d_valid_q <= 1'b1;
          busy_q    <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
          par_q     <= start_bit;
`endif
        end
      end else if (frame_end) begin
        if (frame_cnt != '0) begin
          state     <= S_SHIFT;
          frame_cnt <= frame_cnt - 1'b1;
          idx       <= len_m1;
          d_out_q   <= first_bit;
`ifdef SEQ_TX_PARITY_EN
          par_q     <= first_bit;
`endif
        end else begin
          state     <= S_IDLE;
          d_out_q   <= IDLE_LVL;
          d_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
        end
      end else if (idx != '0) begin
        idx     <= idx - LEN_ONE;
        d_out_q <= next_bit;
`ifdef SEQ_TX_PARITY_EN
        par_q   <= par_q ^ next_bit;
      end else begin
        // par_q already covers every frame bit, including the one on the line now.
        state   <= S_PAR;
        d_out_q <= par_q;
`endif
      end
    end
  end

  assign bus.D_out   = d_out_q;
  assign bus.D_valid = d_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - table-driven bench for seq_pattern_tx
module tb_seq_pattern_tx;
  localparam int   PAT_W    = 8;
  localparam int   LEN_W    = 4;
  localparam int   REP_W    = 4;
  localparam logic IDLE_LVL = 1'b0;
`ifdef SEQ_TX_PARITY_EN
  localparam bit   PAR_EN   = 1'b1;
`else
  localparam bit   PAR_EN   = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .REP_W(REP_W)) bus ();

  seq_pattern_tx #(
    .PAT_W(PAT_W), .LEN_W(LEN_W), .REP_W(REP_W), .IDLE_LVL(IDLE_LVL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic [3:0] rep;
    logic [7:0] frame;
    int         len;
  } vec_t;

  vec_t vecs[10];
  bit   exp_bits[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic build(input vec_t v);
    exp_bits.delete();
    for (int f = 0; f <= int'(v.rep); f++) begin
      bit p;
      p = 1'b0;
      for (int i = v.len - 1; i >= 0; i--) begin
        exp_bits.push_back(v.frame[i]);
        p = p ^ v.frame[i];
      end
      if (PAR_EN) exp_bits.push_back(p);
    end
  endtask

  task automatic check_idle(input string nm, input logic exp_done);
    check({nm, "_dout"}, bus.D_out, IDLE_LVL);
    check({nm, "_valid"}, bus.D_valid, 1'b0);
    check({nm, "_busy"}, bus.busy, 1'b0);
    check({nm, "_done"}, bus.done, exp_done);
  endtask

  // Operands are scrambled after acceptance and start is re-pulsed mid-frame.
  task automatic run_vec(input vec_t v, input int id);
    string nm;
    build(v);
    @(negedge clk);
    bus.start = 1'b1;
    bus.pattern = v.pattern;
    bus.pat_len = v.pat_len;
    bus.rep = v.rep;
    for (int k = 0; k < exp_bits.size(); k++) begin
      @(negedge clk);
      bus.start = (k == 2);
      bus.pattern = ~v.pattern;
      bus.pat_len = 4'd1;
      bus.rep = 4'd0;
      nm = $sformatf("v%0d_b%0d", id, k);
      check({nm, "_dout"}, bus.D_out, exp_bits[k]);
      check({nm, "_valid"}, bus.D_valid, 1'b1);
      check({nm, "_busy"}, bus.busy, 1'b1);
      check({nm, "_done"}, bus.done, 1'b0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check_idle($sformatf("v%0d_end", id), 1'b1);
    @(negedge clk);
    check_idle($sformatf("v%0d_post", id), 1'b0);
  endtask

  task automatic watch_no_done(input string nm, input int cycles);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check(nm, seen, 1'b0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{8'h06, 4'd4,  4'd0,  8'h06, 4};
    vecs[1] = '{8'h0F, 4'd4,  4'd2,  8'h0F, 4};
    vecs[2] = '{8'hA5, 4'd0,  4'd0,  8'hA5, 8};
    vecs[3] = '{8'h07, 4'd3,  4'd0,  8'h07, 3};
    vecs[4] = '{8'hA5, 4'd9,  4'd0,  8'hA5, 8};
    vecs[5] = '{8'hFE, 4'd1,  4'd3,  8'h00, 1};
    vecs[6] = '{8'h5A, 4'd2,  4'd1,  8'h02, 2};
    vecs[7] = '{8'h80, 4'd8,  4'd0,  8'h80, 8};
    vecs[8] = '{8'hC3, 4'd15, 4'd15, 8'hC3, 8};
    vecs[9] = '{8'hF6, 4'd4,  4'd0,  8'h06, 4};

    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.pattern = 8'hFF;
    bus.pat_len = 4'd4;
    bus.rep = 4'd0;
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_c1", 1'b0);
    @(negedge clk);
    check_idle("rst_c2", 1'b0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check_idle("rst_rel", 1'b0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Back-to-back: restart in the done cycle, first bit one cycle later.
    v = vecs[1];
    build(v);
    @(negedge clk);
    bus.start = 1'b1;
    bus.pattern = v.pattern;
    bus.pat_len = v.pat_len;
    bus.rep = v.rep;
    for (int k = 0; k < exp_bits.size(); k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check($sformatf("chain_b%0d_dout", k), bus.D_out, exp_bits[k]);
      check($sformatf("chain_b%0d_valid", k), bus.D_valid, 1'b1);
    end
    @(negedge clk);
    check("chain_done", bus.done, 1'b1);
    bus.start = 1'b1;
    bus.pattern = 8'h01;
    bus.pat_len = 4'd1;
    bus.rep = 4'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check("chain_first_dout", bus.D_out, 1'b1);
    check("chain_first_valid", bus.D_valid, 1'b1);
    check("chain_first_done", bus.done, 1'b0);
    if (PAR_EN) begin
      @(negedge clk);
      check("chain_par_dout", bus.D_out, 1'b1);
      check("chain_par_valid", bus.D_valid, 1'b1);
    end
    @(negedge clk);
    check_idle("chain_end", 1'b1);

    // Abort during the third bit.
    @(negedge clk);
    bus.start = 1'b1;
    bus.pattern = 8'hA5;
    bus.pat_len = 4'd0;
    bus.rep = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check("abort_b0", bus.D_out, 1'b1);
    @(negedge clk);
    check("abort_b1", bus.D_out, 1'b0);
    @(negedge clk);
    check("abort_b2", bus.D_out, 1'b1);
    check("abort_b2_busy", bus.busy, 1'b1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_idle("abort_after", 1'b0);
    watch_no_done("abort_no_done", 40);

    // Abort together with start in idle drops the start.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_idle("abort_idle_c1", 1'b0);
    @(negedge clk);
    check_idle("abort_idle_c2", 1'b0);

    // Reset mid-frame.
    @(negedge clk);
    bus.start = 1'b1;
    bus.pattern = 8'h06;
    bus.pat_len = 4'd4;
    bus.rep = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("rstmid_b0", bus.D_out, 1'b0);
    @(negedge clk);
    check("rstmid_b1", bus.D_out, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rstmid_after", 1'b0);
    watch_no_done("rstmid_no_done", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial bit-pattern transmitter: the driving end of the single-bit `D_in` stream consumed by the Moore/Mealy sequence detectors. On `start` it latches a pattern, a length and a repeat count, then shifts the pattern out MSB-first on `D_out`, one bit per clock, back-to-back for the requested number of frames. It is used as the on-chip stimulus source for detector self-test and as the reference transmitter in detector benches.

## Interface
- `PAT_W`, default 8: maximum pattern length in bits (≥2).
- `LEN_W`, default `$clog2(PAT_W)+1`: width of `pat_len`.
- `REP_W`, default 4: width of `rep`.
- `IDLE_LVL`, default 1'b0: level driven on `D_out` when no frame bit is being sent.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `abort`  in  1  cancel transmission; priority over `start`.
- `pattern`  in  PAT_W  bits to send; only the low `pat_len` bits are used.
- `pat_len`  in  LEN_W  frame length 1..PAT_W; 0 or >PAT_W means PAT_W.
- `rep`  in  REP_W  extra repeats; total frames = rep+1.
- `D_out`  out  1  serial data, registered.
- `D_valid`  out  1  high while `D_out` carries a frame (or parity) bit.
- `busy`  out  1  high from first bit through last bit.
- `done`  out  1  one-cycle pulse after the last bit of the last frame.

## Operation
- States: IDLE, SHIFT, PAR (PAR exists only with the macro).
- IDLE: `start`=1 and `abort`=0 latches `pattern`, effective length L, and `rep`. Bit index = L-1, frame counter = rep. Next state is SHIFT.
- SHIFT: drive `pattern[idx]` with `D_valid`=1, `busy`=1, then decrement idx.
  - After idx 0: go to PAR if the macro is defined.
  - Otherwise, if frames remain, reload idx=L-1 and decrement the frame counter, with no gap cycle.
  - Otherwise return to IDLE and pulse `done`.
- PAR: drive the parity bit for one cycle, then follow the same frame-end rule.
- Latched operands are immune to input changes during a transmission. `start` while busy is ignored (no queueing).
- `abort`=1 while busy: in the next cycle `D_out`=IDLE_LVL, `D_valid`=0, `busy`=0, state IDLE, no `done`. `abort` in IDLE has no effect, and a simultaneous `start` is dropped.
- `rst` takes effect at any cycle, including mid-frame. After reset: `D_out`=IDLE_LVL, `D_valid`=0, `busy`=0, `done`=0, counters 0, state IDLE.

## Timing
- `start` sampled at edge T: first bit is valid in cycle T+1.
- Frame bits occupy N = (rep+1)·F consecutive cycles T+1..T+N. F=L, or L+1 with parity.
- `done`=1 in cycle T+N+1 only. `busy`=0 in that same cycle, and a new `start` is accepted there. Minimum inter-transmission gap is 1 idle cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- The maximum transmission is (2^REP_W)·(PAT_W+1) bits. Counters must not wrap within that range.

## Configuration
- `SEQ_TX_PARITY_EN` defined: after each frame, one extra bit is sent with `D_valid`=1. Its value is the even-parity bit, i.e. the XOR of the L frame bits. F=L+1.
- Not defined: no PAR state and no parity logic. F=L.

## Test plan
- Reset: hold `rst` 2 cycles with `start`=1 → `D_out`=0, `D_valid`=0, `busy`=0, `done`=0 throughout and one cycle after release.
- `pattern`=8'h06, `pat_len`=4, `rep`=0, `start` at T → `D_out`=0,1,1,0 in T+1..T+4, `done` at T+5, `D_out`=0 at T+5. A detector for 0110 fires.
- `pattern`=8'h0F, `pat_len`=4, `rep`=2 → twelve consecutive 1s with `D_valid`=1 in T+1..T+12, `done` only at T+13. Re-`start` at T+13 gives its first bit at T+14.
- `pattern`=8'hA5, `pat_len`=0 → 8 bits 1,0,1,0,0,1,0,1. `start` pulsed at T+3 is ignored, with exactly one `done` at T+9.
- `abort` at T+3 (3rd bit) → `D_valid`=0, `busy`=0 from T+4, no `done`. Likewise `rst` at T+2 → idle outputs from T+3.
- `pattern`=8'h07, `pat_len`=3: with `SEQ_TX_PARITY_EN` → 1,1,1,1, `done` at T+5. Without it → 1,1,1, `done` at T+4.
